// File: rtl/legv8_trace_pkg.sv
// Shared types for the LEGv8 execution-trace buffer: FSM states, trigger modes
// and the packed layout of one captured retire record.
package legv8_trace_pkg;

  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_INSTR_W = 32;
  localparam int TRACE_DATA_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE   = 2'd0,
    TRIG_PC_MATCH    = 2'd1,
    TRIG_INSTR_MATCH = 2'd2,
    TRIG_FLAGS_MATCH = 2'd3
  } trig_mode_t;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_INSTR_W-1:0] instr;
    logic [3:0]               flags;
    logic                     wr_en;
    logic [4:0]               wr_reg;
    logic [TRACE_DATA_W-1:0]  wr_data;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/legv8_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The read register holds its value while re is low, acting as the output hold.
module legv8_trace_ram #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 138,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents after
  // reset are undefined and every consumer is gated by a reset-cleared valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/legv8_trace_buffer.sv
// Execution-trace capture unit: circular capture while armed, programmable
// trigger, post-trigger window, then oldest-first streaming over valid/ready.
module legv8_trace_buffer
  import legv8_trace_pkg::*;
#(
  parameter  int PC_W    = TRACE_PC_W,
  parameter  int INSTR_W = TRACE_INSTR_W,
  parameter  int DATA_W  = TRACE_DATA_W,
  parameter  int DEPTH   = 256,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = PC_W + INSTR_W + 4 + 1 + 5 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               disarm,
  input  logic [1:0]         trig_mode,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [INSTR_W-1:0] trig_instr,
  input  logic [INSTR_W-1:0] trig_instr_mask,
  input  logic [3:0]         trig_flags,
  input  logic [AW-1:0]      post_count,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    cap_pc,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic [3:0]         cap_flags,
  input  logic               cap_wr_en,
  input  logic [4:0]         cap_wr_reg,
  input  logic [DATA_W-1:0]  cap_wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [AW:0]        entry_count,
  output logic               wrapped
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  trace_state_t        state_q, state_d;
  logic                trig_hit;
  logic                ctl_free;
  logic                cap_write;
  logic                enter_done;
  logic                rd_fetch;
  logic                rd_load, rd_start;
  logic [AW-1:0]       wr_ptr, rd_ptr, post_left;
  logic [AW:0]         rd_left;
  logic [ENTRY_W-1:0]  ram_q;

  assign ctl_free  = !arm && !disarm;
  assign cap_write = ctl_free && cap_valid && (state_q == ARMED || state_q == POST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_t'(trig_mode))
      TRIG_IMMEDIATE:   trig_hit = 1'b1;
      TRIG_PC_MATCH:    trig_hit = (cap_pc == trig_pc);
      TRIG_INSTR_MATCH: trig_hit = ((cap_instr ^ trig_instr) & trig_instr_mask) == '0;
      TRIG_FLAGS_MATCH: trig_hit = (cap_flags == trig_flags);
      default:          trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = IDLE;
    end else if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: if (cap_valid && trig_hit) state_d = (post_count == '0) ? DONE : POST;
        POST:  if (cap_valid && post_left == AW'(1)) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign rd_fetch   = ctl_free && (rd_start || (rd_valid && rd_ready && !rd_last));

  // Readout pipeline: rd_load computes the oldest pointer, rd_start issues the
  // first RAM read, after which each accepted entry prefetches the next one.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      post_left   <= '0;
      rd_left     <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      rd_load     <= 1'b0;
      rd_start    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else if (disarm) begin
      rd_load  <= 1'b0;
      rd_start <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (arm) begin
      wr_ptr      <= '0;
      post_left   <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      rd_load     <= 1'b0;
      rd_start    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      if (cap_write) begin
        wr_ptr    <= wr_ptr + AW'(1);
        post_left <= (state_q == ARMED) ? post_count : post_left - AW'(1);
        if (entry_count == FULL) wrapped <= 1'b1;
        else                     entry_count <= entry_count + (AW + 1)'(1);
      end
      rd_load  <= enter_done;
      rd_start <= rd_load;
      if (rd_load) begin
        rd_ptr  <= wr_ptr - entry_count[AW-1:0];
        rd_left <= entry_count;
      end
      if (rd_fetch) begin
        rd_ptr   <= rd_ptr + AW'(1);
        rd_left  <= rd_left - (AW + 1)'(1);
        rd_last  <= (rd_left == (AW + 1)'(1));
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  legv8_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (cap_write),
    .waddr (wr_ptr),
    .wdata ({cap_pc, cap_instr, cap_flags, cap_wr_en, cap_wr_reg, cap_wr_data}),
    .re    (rd_fetch),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign rd_data = rd_valid ? ram_q : '0;
  assign state   = state_q;

endmodule

// File: tb/tb_legv8_trace_buffer.sv
// Self-checking bench for legv8_trace_buffer (DEPTH=8): queue-based reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_legv8_trace_buffer;
  import legv8_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm = 1'b0, disarm = 1'b0;
  logic [1:0]        trig_mode = 2'd0;
  logic [31:0]       trig_pc = '0, trig_instr = '0, trig_instr_mask = '0;
  logic [3:0]        trig_flags = '0;
  logic [AW-1:0]     post_count = '0;
  logic              cap_valid = 1'b0;
  logic [31:0]       cap_pc = '0, cap_instr = '0;
  logic [3:0]        cap_flags = '0;
  logic              cap_wr_en = 1'b0;
  logic [4:0]        cap_wr_reg = '0;
  logic [63:0]       cap_wr_data = '0;
  logic              rd_valid, rd_ready = 1'b0, rd_last, wrapped;
  logic [TRACE_ENTRY_W-1:0] rd_data;
  logic [1:0]        state;
  logic [AW:0]       entry_count;

  legv8_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .trig_instr(trig_instr), .trig_instr_mask(trig_instr_mask),
    .trig_flags(trig_flags), .post_count(post_count), .cap_valid(cap_valid),
    .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_flags(cap_flags),
    .cap_wr_en(cap_wr_en), .cap_wr_reg(cap_wr_reg), .cap_wr_data(cap_wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .entry_count(entry_count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the buffer is the list of the last DEPTH captured records.
  trace_entry_t hist[$];
  trace_entry_t got_q[$];
  int  m_state = 0, m_left = 0, m_age = 0, m_rd_idx = 0;
  bit  m_wrapped = 0;

  function automatic bit m_trig();
    case (trig_mode)
      2'd0:    return 1'b1;
      2'd1:    return cap_pc == trig_pc;
      2'd2:    return (cap_instr & trig_instr_mask) == (trig_instr & trig_instr_mask);
      default: return cap_flags == trig_flags;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_left = 0; m_age = 0; m_rd_idx = 0; m_wrapped = 0;
      hist.delete();
    end else begin
      if (m_state == 3 && m_age >= 2 && m_rd_idx < hist.size() && rd_ready) m_rd_idx++;
      if (m_state == 3) m_age++;
      if (disarm) begin
        m_state = 0;
      end else if (arm) begin
        m_state = 1; m_wrapped = 0; m_rd_idx = 0; m_age = 0;
        hist.delete();
      end else if (cap_valid && (m_state == 1 || m_state == 2)) begin
        if (hist.size() == DEPTH) begin
          hist.delete(0);
          m_wrapped = 1;
        end
        hist.push_back('{pc: cap_pc, instr: cap_instr, flags: cap_flags,
                         wr_en: cap_wr_en, wr_reg: cap_wr_reg, wr_data: cap_wr_data});
        if (m_state == 1) begin
          if (m_trig()) begin
            if (post_count == 0) begin m_state = 3; m_age = 0; end
            else begin m_state = 2; m_left = int'(post_count); end
          end
        end else begin
          m_left--;
          if (m_left == 0) begin m_state = 3; m_age = 0; end
        end
      end
    end
  end

  bit           stalled_prev = 0;
  logic [TRACE_ENTRY_W-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      bit exp_valid;
      exp_valid = (m_state == 3 && m_age >= 2 && m_rd_idx < hist.size());
      check("state", state, m_state);
      check("entry_count", entry_count, hist.size());
      check("wrapped", wrapped, m_wrapped);
      check("rd_valid", rd_valid, exp_valid);
      if (exp_valid) begin
        check("rd_data", rd_data, hist[m_rd_idx]);
        check("rd_last", rd_last, m_rd_idx == hist.size() - 1);
        if (rd_ready) got_q.push_back(trace_entry_t'(rd_data));
      end
      if (stalled_prev && rd_valid) check("rd_stable", rd_data, prev_data);
      stalled_prev = rd_valid && !rd_ready;
      prev_data    = rd_data;
    end else begin
      stalled_prev = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] flags);
    cap_valid   = 1'b1;
    cap_pc      = pc;
    cap_instr   = instr;
    cap_flags   = flags;
    cap_wr_en   = pc[2];
    cap_wr_reg  = pc[6:2];
    cap_wr_data = {pc, ~pc};
    step();
    cap_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [AW-1:0] pcnt);
    trig_mode  = mode;
    post_count = pcnt;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int limit);
    int n = 0;
    while (!(m_state == 3 && m_age >= 2 && m_rd_idx == hist.size()) && n < limit) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d entries expected %0d", m_rd_idx, hist.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_count", entry_count, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step();

    // IMMEDIATE trigger, 3 post entries, extra retires after DONE are ignored
    rd_ready = 1'b1;
    got_q.delete();
    do_arm(2'd0, 3'd3);
    check("t1_armed", state, 1);
    for (int i = 0; i < 10; i++) begin
      retire(32'(i * 4), 32'h8B00_0000, 4'h0);
      if (i == 2) check("t1_post", state, 2);
      if (i == 3) check("t1_done", state, 3);
    end
    drain(1'b0, 50);
    check("t1_n", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_pc", got_q[i].pc, i * 4);
    check("t1_model_last_pc", hist[hist.size() - 1].pc, 12);
    repeat (3) step();
    check("t1_no_restream", rd_valid, 0);
    check("t1_stay_done", state, 3);

    // PC_MATCH with wrap-around of pre-trigger history, random back-pressure
    rd_ready = 1'b0;
    got_q.delete();
    trig_pc = 32'h40;
    do_arm(2'd1, 3'd2);
    for (int i = 0; i <= 24; i++) retire(32'(i * 4), 32'hCB01_0020, 4'h8);
    check("t2_wrapped", wrapped, 1);
    check("t2_count", entry_count, 8);
    drain(1'b1, 200);
    check("t2_n", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_pc", got_q[i].pc, 32'h2C + 4 * i);
    check("t2_trig_idx", got_q[5].pc, 32'h40);

    // INSTR_MATCH on ADD opcode; earlier SUB/LDUR kept, only first ADD triggers
    rd_ready = 1'b0;
    got_q.delete();
    trig_instr      = 32'h8B00_0000;
    trig_instr_mask = 32'hFFE0_0000;
    do_arm(2'd2, 3'd2);
    retire(32'h80, 32'hCB01_0020, 4'h0);
    retire(32'h84, 32'hF840_0041, 4'h0);
    retire(32'h88, 32'h8B02_0062, 4'h0);
    check("t3_post", state, 2);
    retire(32'h8C, 32'hCB03_0083, 4'h0);
    retire(32'h90, 32'h8B04_00A4, 4'h0);
    check("t3_done", state, 3);
    drain(1'b1, 200);
    check("t3_n", got_q.size(), 5);
    check("t3_i0", got_q[0].instr, 32'hCB01_0020);
    check("t3_i1", got_q[1].instr, 32'hF840_0041);
    check("t3_i2", got_q[2].instr, 32'h8B02_0062);
    check("t3_i4", got_q[4].instr, 32'h8B04_00A4);

    // FLAGS_MATCH then disarm in POST; arm/disarm priority; arm ignores capture
    trig_flags = 4'b0110;
    do_arm(2'd3, 3'd3);
    retire(32'h100, 32'h0, 4'h0);
    retire(32'h104, 32'h0, 4'h0);
    retire(32'h108, 32'h0, 4'h6);
    check("t4_post", state, 2);
    retire(32'h10C, 32'h0, 4'h0);
    disarm = 1'b1; step(); disarm = 1'b0;
    check("t4_disarm", state, 0);
    check("t4_disarm_valid", rd_valid, 0);
    arm = 1'b1; disarm = 1'b1; step(); arm = 1'b0; disarm = 1'b0;
    check("t4_both", state, 0);
    got_q.delete();
    trig_mode = 2'd0; post_count = 3'd0;
    arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h1F0; step(); arm = 1'b0; cap_valid = 1'b0;
    check("t4_arm_state", state, 1);
    check("t4_arm_cap", entry_count, 0);
    retire(32'h110, 32'h0, 4'h0);
    check("t4_done", state, 3);
    check("t4_count", entry_count, 1);
    drain(1'b0, 50);
    check("t4_n", got_q.size(), 1);
    check("t4_pc", got_q[0].pc, 32'h110);

    // asynchronous reset in the middle of a stalled readout
    rd_ready = 1'b0;
    do_arm(2'd0, 3'd5);
    for (int i = 0; i < 6; i++) retire(32'h200 + 32'(i * 4), 32'h0, 4'h0);
    begin
      int n = 0;
      while (!rd_valid && n < 20) begin step(); n++; end
      check("t5_valid_rise", rd_valid, 1);
    end
    repeat (2) step();
    rd_ready = 1'b1;
    repeat (2) step();
    rd_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", rd_valid, 0);
    check("t5_rst_state", state, 0);
    check("t5_rst_count", entry_count, 0);
    check("t5_rst_data", rd_data, 0);
    step();
    rst = 1'b0;
    step();
    got_q.delete();
    do_arm(2'd0, 3'd1);
    retire(32'h300, 32'h0, 4'h0);
    retire(32'h304, 32'h0, 4'h0);
    drain(1'b0, 50);
    check("t5_n", got_q.size(), 2);
    check("t5_pc0", got_q[0].pc, 32'h300);
    check("t5_pc1", got_q[1].pc, 32'h304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
